// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART program loader
// Contents: protocol FSM state enum, err_code values, default sync byte,
//           instruction-memory address width.
package loader_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_LEN   = 2'b01;
    localparam logic [1:0] ERR_FRAME = 2'b10;
    localparam logic [1:0] ERR_SUM   = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         ADDR_W            = 5;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART byte receiver with input synchroniser
// Ports: clk, rst_n (async, active-low), rx (async serial line, idle high)
//        byte_valid (1-cycle pulse), byte_data[7:0], frame_err (1-cycle pulse)
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    // Edge rather than level, so a stuck-low line after a
                    // framing error does not immediately start another byte.
                    if (rx_prev && !rx_sync) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/prog_loader_uart.sv
// rtl/prog_loader_uart.sv - UART program loader for the accumulator core's instruction memory
// Ports: clk, rst_n (async, active-low), rx (UART line)
//        mem_we/mem_addr[4:0]/mem_wdata[7:0] (instruction-memory write port)
//        busy (core load mode), done (end-of-frame pulse), load_ok, err_code[1:0]
module prog_loader_uart
    import loader_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         MEM_DEPTH    = 21,
    parameter int         TIMEOUT_CLKS = 4096,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              load_ok,
    output logic [1:0]        err_code
);

    localparam int            TW           = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] len_last;  // len-1, so the counter stops at the last address
    logic [7:0]        sum;
    logic [TW-1:0]     idle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_SYNC;
            cnt       <= '0;
            len_last  <= '0;
            sum       <= '0;
            idle_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_ok   <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            if (state == WAIT_SYNC || byte_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            case (state)
                WAIT_SYNC: begin
                    if (byte_valid && byte_data == SYNC_BYTE) begin
                        busy     <= 1'b1;
                        load_ok  <= 1'b0;
                        err_code <= ERR_NONE;
                        cnt      <= '0;
                        sum      <= '0;
                        state    <= GET_LEN;
                    end
                end
                default: begin
                    if (frame_err || (!byte_valid && idle_cnt == TIMEOUT_LAST)) begin
                        err_code <= ERR_FRAME;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= WAIT_SYNC;
                    end else if (byte_valid) begin
                        case (state)
                            GET_LEN: begin
                                if (byte_data == 8'd0 || byte_data > 8'(MEM_DEPTH)) begin
                                    err_code <= ERR_LEN;
                                    done     <= 1'b1;
                                    busy     <= 1'b0;
                                    state    <= WAIT_SYNC;
                                end else begin
                                    len_last <= ADDR_W'(byte_data - 8'd1);
                                    state    <= GET_DATA;
                                end
                            end
                            GET_DATA: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= cnt;
                                mem_wdata <= byte_data;
                                sum       <= sum + byte_data;
                                if (cnt == len_last) begin
                                    state <= GET_SUM;
                                end else begin
                                    cnt <= cnt + 1'b1;
                                end
                            end
                            GET_SUM: begin
                                load_ok  <= (byte_data == sum);
                                err_code <= (byte_data == sum) ? ERR_NONE : ERR_SUM;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= WAIT_SYNC;
                            end
                            default: state <= WAIT_SYNC;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader_uart.sv
// tb/tb_prog_loader_uart.sv - scoreboard testbench for prog_loader_uart
module tb_prog_loader_uart;

    localparam int CPB       = 16;
    localparam int MEM_DEPTH = 21;
    localparam int TIMEOUT   = 4096;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       load_ok;
    logic [1:0] err_code;

    int n_tests = 0;
    int n_fail  = 0;

    logic [12:0] wq[$];   // expected writes {addr, data}
    logic [2:0]  dq[$];   // expected done status {load_ok, err_code}
    logic [7:0]  pay[$];  // payload for the next send_frame

    always #5 clk = ~clk;

    prog_loader_uart #(
        .CLKS_PER_BIT(CPB),
        .MEM_DEPTH   (MEM_DEPTH),
        .TIMEOUT_CLKS(TIMEOUT),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .load_ok  (load_ok),
        .err_code (err_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = stop;
        wait_bits(1);
        rx = 1'b1;
        if (!stop) wait_bits(2);
    endtask

    // Sync byte, then len byte, then pay[] as data and sum_byte, unless len is
    // out of range, in which case only the length error is expected.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] sum_byte);
        logic [7:0] s;
        s = 8'h00;
        send_byte(8'hA5, 1'b1);
        check("busy_after_sync", busy, 1);
        check("err_clear_after_sync", err_code, 0);
        check("load_ok_clear_after_sync", load_ok, 0);
        if (len == 8'd0 || len > 8'(MEM_DEPTH)) begin
            dq.push_back({1'b0, 2'b01});
            send_byte(len, 1'b1);
        end else begin
            send_byte(len, 1'b1);
            for (int i = 0; i < pay.size(); i++) begin
                wq.push_back({5'(i), pay[i]});
                s = s + pay[i];
                send_byte(pay[i], 1'b1);
            end
            dq.push_back((sum_byte == s) ? {1'b1, 2'b00} : {1'b0, 2'b11});
            send_byte(sum_byte, 1'b1);
        end
    endtask

    task automatic drain(input string tag);
        wait_bits(2);
        check({tag, "_writes_seen"}, wq.size(), 0);
        check({tag, "_done_seen"}, dq.size(), 0);
        check({tag, "_busy_low"}, busy, 0);
        wq.delete();
        dq.delete();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && done) check("we_done_overlap", 1, 0);
            if (mem_we) begin
                check("write_expected", 32'(wq.size() > 0), 1);
                if (wq.size() > 0) check("write_addr_data", {mem_addr, mem_wdata}, wq.pop_front());
            end
            if (done) begin
                check("done_expected", 32'(dq.size() > 0), 1);
                if (dq.size() > 0) check("done_status", {load_ok, err_code}, dq.pop_front());
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_outputs", {mem_we, mem_addr, mem_wdata, busy, done, load_ok, err_code}, 0);
        rst_n = 1'b1;
        wait_bits(1);

        // good frame
        pay = '{8'h01, 8'h2A, 8'h0A};
        send_frame(8'd3, 8'h35);
        drain("good");
        check("good_load_ok", load_ok, 1);
        check("good_err", err_code, 0);

        // bad checksum
        pay = '{8'h10, 8'h20};
        send_frame(8'd2, 8'h31);
        drain("badsum");
        check("badsum_err", err_code, 2'b11);

        // bad lengths
        send_frame(8'd0, 8'h00);
        drain("len0");
        send_frame(8'h16, 8'h00);
        drain("len22");
        check("len22_err", err_code, 2'b01);

        // framing error mid-frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        wq.push_back({5'd0, 8'h11});
        send_byte(8'h11, 1'b1);
        dq.push_back({1'b0, 2'b10});
        send_byte(8'h22, 1'b0);
        drain("frame");

        // timeout mid-frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        wq.push_back({5'd0, 8'h11});
        dq.push_back({1'b0, 2'b10});
        send_byte(8'h11, 1'b1);
        repeat (TIMEOUT + CPB) @(negedge clk);
        drain("timeout");
        check("timeout_err_held", err_code, 2'b10);

        // next sync clears the error, then a one-byte frame completes
        pay = '{8'h7F};
        send_frame(8'd1, 8'h7F);
        drain("after_timeout");

        // noise and a short glitch before a good frame
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx = 1'b1;
        wait_bits(3);
        check("noise_busy_low", busy, 0);
        pay = '{8'hC3, 8'hA5, 8'h10};
        send_frame(8'd3, 8'h78);
        drain("noise");
        check("noise_load_ok", load_ok, 1);

        // reset in the middle of a frame
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        wq.push_back({5'd0, 8'h01});
        send_byte(8'h01, 1'b1);
        wq.push_back({5'd1, 8'h02});
        send_byte(8'h02, 1'b1);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", {mem_we, mem_addr, mem_wdata, busy, done, load_ok, err_code}, 0);
        check("midreset_writes_seen", wq.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_bits(1);
        pay = '{8'h33, 8'h44};
        send_frame(8'd2, 8'h77);
        drain("after_reset");
        check("after_reset_load_ok", load_ok, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
